// File: rtl/alu_issue_pkg.sv
// Shared decode constants, field positions and the issued operand bundle.
package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SH_MSB = 10;
  localparam int SH_LSB = 6;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  shamt;
    logic [5:0]  alu_control;
    logic [15:0] immediate;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [4:0]  rd_addr;
  } issue_t;

  // R-type writes rd; everything else targets rt.
  function automatic logic [4:0] dest_addr(input logic [31:0] instr);
    if (instr[OP_MSB:OP_LSB] == OP_RTYPE)
      return instr[RD_MSB:RD_LSB];
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/reg_file.sv
// Two async read ports, one sync write port, r0 hard-wired zero,
// and write-before-read bypass on both read ports.
module reg_file #(
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  logic [31:0] mem [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++)
        mem[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0
                 && 32'(wb_addr) < REG_COUNT) begin
      mem[wb_addr] <= wb_data;
    end
  end

  function automatic logic [31:0] rd(input logic [4:0] a);
    if (a == 5'd0 || 32'(a) >= REG_COUNT)
      return '0;
    if (wb_en && wb_addr == a)
      return wb_data;
    return mem[a];
  endfunction

  always_comb begin
    ra_data = rd(ra_addr);
    rb_data = rd(rb_addr);
  end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: reads operands, registers the ALU bundle,
// stalls on alu_ready and drops work on flush.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instruction,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  input  logic             alu_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [5:0]       opcode,
  output logic [4:0]       shamt,
  output logic [5:0]       ALU_control,
  output logic [15:0]      immediate,
  output logic [31:0]      rs_content,
  output logic [31:0]      rt_content,
  output logic [4:0]       rd_addr,
  output logic [CNT_W-1:0] issue_count
);

  issue_t      q;
  issue_t      d;
  logic        valid_q;
  logic        accept;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  reg_file #(.REG_COUNT(REG_COUNT)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (instruction[RS_MSB:RS_LSB]),
    .ra_data (rs_val),
    .rb_addr (instruction[RT_MSB:RT_LSB]),
    .rb_data (rt_val),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  assign instr_ready = !flush && (!valid_q || alu_ready);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    d             = '0;
    d.opcode      = instruction[OP_MSB:OP_LSB];
    d.shamt       = instruction[SH_MSB:SH_LSB];
    d.immediate   = instruction[IM_MSB:IM_LSB];
    d.rs_content  = rs_val;
    d.rt_content  = rt_val;
    d.rd_addr     = dest_addr(instruction);
    if (d.opcode == OP_RTYPE)
      d.alu_control = instruction[FN_MSB:FN_LSB];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      valid_q     <= 1'b0;
      issue_count <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      q       <= d;
      valid_q <= 1'b1;
      if (issue_count != '1)
        issue_count <= issue_count + 1'b1;
    end else if (alu_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign opcode      = q.opcode;
  assign shamt       = q.shamt;
  assign ALU_control = q.alu_control;
  assign immediate   = q.immediate;
  assign rs_content  = q.rs_content;
  assign rt_content  = q.rt_content;
  assign rd_addr     = q.rd_addr;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue; counter width shrunk to 3 bits
// so saturation is reachable.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        alu_ready;
  logic        flush;
  logic        out_valid;
  logic [5:0]  opcode;
  logic [4:0]  shamt;
  logic [5:0]  ALU_control;
  logic [15:0] immediate;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic [4:0]  rd_addr;
  logic [2:0]  issue_count;

  int checks = 0;
  int errors = 0;

  alu_issue #(.REG_COUNT(32), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .alu_ready   (alu_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .opcode      (opcode),
    .shamt       (shamt),
    .ALU_control (ALU_control),
    .immediate   (immediate),
    .rs_content  (rs_content),
    .rt_content  (rt_content),
    .rd_addr     (rd_addr),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] v);
    wb_en = 1'b1; wb_addr = a; wb_data = v;
    step();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins);
    instruction = ins; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instruction = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    alu_ready = 1'b1; flush = 1'b0;
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(issue_count), 32'd0);
    check("rst_rs", rs_content, 32'd0);
    check("rst_rd", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);

    // addi r9,r8,13
    wb(5'd8, 32'd15);
    issue(32'h2109000D);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_op", 32'(opcode), 32'h08);
    check("addi_rs", rs_content, 32'd15);
    check("addi_imm", 32'(immediate), 32'd13);
    check("addi_rd", 32'(rd_addr), 32'd9);
    check("addi_ctl", 32'(ALU_control), 32'd0);
    check("addi_cnt", 32'(issue_count), 32'd1);
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // add r10,r8,r9
    wb(5'd8, 32'd23);
    wb(5'd9, 32'd12);
    issue(32'h01095020);
    check("add_rs", rs_content, 32'd23);
    check("add_rt", rt_content, 32'd12);
    check("add_ctl", 32'(ALU_control), 32'h20);
    check("add_rd", 32'(rd_addr), 32'd10);
    check("add_op", 32'(opcode), 32'd0);
    check("add_cnt", 32'(issue_count), 32'd2);

    // stall three cycles with addi r9,r9,1 pending
    alu_ready = 1'b0; instr_valid = 1'b1; instruction = 32'h21290001;
    #1;
    check("stall_ready", 32'(instr_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_rs", rs_content, 32'd23);
      check("stall_rd", 32'(rd_addr), 32'd10);
      check("stall_cnt", 32'(issue_count), 32'd2);
      check("stall_rdy", 32'(instr_ready), 32'd0);
    end
    alu_ready = 1'b1;
    #1;
    check("release_ready", 32'(instr_ready), 32'd1);
    step();
    instr_valid = 1'b0;
    check("release_op", 32'(opcode), 32'h08);
    check("release_rs", rs_content, 32'd12);
    check("release_imm", 32'(immediate), 32'd1);
    check("release_rd", 32'(rd_addr), 32'd9);
    check("release_cnt", 32'(issue_count), 32'd3);

    // same-cycle writeback bypass on rs=8
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEADBEEF;
    issue(32'h2109000D);
    wb_en = 1'b0;
    check("byp_rs", rs_content, 32'hDEADBEEF);
    check("byp_rt", rt_content, 32'd12);
    check("byp_cnt", 32'(issue_count), 32'd4);

    // later writeback must not touch the registered operand
    alu_ready = 1'b0;
    wb(5'd8, 32'd1);
    check("hold_rs", rs_content, 32'hDEADBEEF);
    check("hold_valid", 32'(out_valid), 32'd1);

    // flush beats alu_ready; writeback still lands
    alu_ready = 1'b1; flush = 1'b1; instr_valid = 1'b1;
    instruction = 32'h01095020;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h77;
    #1;
    check("flush_ready", 32'(instr_ready), 32'd0);
    step();
    flush = 1'b0; instr_valid = 1'b0; wb_en = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_cnt", 32'(issue_count), 32'd4);

    // r0 stays zero even after a write attempt
    wb(5'd0, 32'h55);
    issue(32'h20000005);
    check("r0_rs", rs_content, 32'd0);
    check("r0_imm", 32'(immediate), 32'd5);
    check("r0_rd", 32'(rd_addr), 32'd0);
    check("r0_cnt", 32'(issue_count), 32'd5);
    // add r1,r0,r8
    issue(32'h00080820);
    check("r0b_rs", rs_content, 32'd0);
    check("r0b_rt", rt_content, 32'h77);
    check("r0b_rd", 32'(rd_addr), 32'd1);
    check("r0b_cnt", 32'(issue_count), 32'd6);

    // back-to-back issue into counter saturation
    instruction = 32'h2109000D; instr_valid = 1'b1;
    step();
    check("sat7_cnt", 32'(issue_count), 32'd7);
    step();
    check("sat_cnt", 32'(issue_count), 32'd7);
    check("sat_valid", 32'(out_valid), 32'd1);

    // reset mid-stall drops the bundle and clears the regfile
    alu_ready = 1'b0;
    step();
    rst = 1'b1; flush = 1'b1; wb_en = 1'b1;
    wb_addr = 5'd8; wb_data = 32'h99;
    step();
    rst = 1'b0; flush = 1'b0; wb_en = 1'b0;
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_cnt", 32'(issue_count), 32'd0);
    check("rst2_rs", rs_content, 32'd0);
    alu_ready = 1'b1;
    issue(32'h2109000D);
    check("rst2_r8", rs_content, 32'd0);
    check("rst2_cnt1", 32'(issue_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
